rf_read_port_arbiter: RTL and testbench
=======================================

Name: rf_read_port_arbiter

Overview:
- Shares the regfile's NUM_RF_R_PORTS read ports among ISSUE_WIDTH_MAX issue slots, each needing up to NUM_SRCS reads.
- Grants whole slots (all sources or none) in rotating round-robin order and drives the regfile read addresses the same cycle.
- Emits registered steering (source -> port index) aligned with the regfile's 1-cycle read-data latency.
- Sits between the issue select logic and the regfile.

Parameters:
- ISSUE_WIDTH_MAX, 4, number of issue slots (requesters).
- NUM_SRCS, 2, sources per slot.
- NUM_RF_R_PORTS, 6, regfile read ports. Must be >= NUM_SRCS; elaboration error otherwise.
- SRC_LEN, 5, architectural register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; kills in-flight steering
- iss_req_v  in  [ISSUE_WIDTH_MAX]  slot requests issue
- iss_src_v  in  [ISSUE_WIDTH_MAX][NUM_SRCS]  source needs an RF read
- iss_src_addr  in  [ISSUE_WIDTH_MAX][NUM_SRCS][SRC_LEN]  source register
- iss_gnt  out  [ISSUE_WIDTH_MAX]  combinational grant, same cycle
- rf_r_port_addr  out  [NUM_RF_R_PORTS][SRC_LEN]  combinational, to the regfile
- rf_r_port_en  out  [NUM_RF_R_PORTS]  port carries a granted read
- rd_sel_v  out  [ISSUE_WIDTH_MAX][NUM_SRCS]  registered: read data is valid on the selected port this cycle
- rd_sel_port  out  [ISSUE_WIDTH_MAX][NUM_SRCS][$clog2(NUM_RF_R_PORTS)]  registered port index
- rr_ptr  out  [$clog2(ISSUE_WIDTH_MAX)]  current priority slot (debug/verification)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: rr_ptr=0, rd_sel_v=0, rd_sel_port=0. Combinational outputs follow their inputs, gated: iss_gnt=0 while rst=1.
- Port need per slot:
  - need[i] = count of s where iss_src_v[i][s] && iss_src_addr[i][s] != 0.
  - x0 sources never consume a port; the consumer forces zero.
  - Identical addresses are not merged; each source takes its own port.
- Allocation (combinational):
  - Walk slots k = rr_ptr, rr_ptr+1, ... mod ISSUE_WIDTH_MAX, with avail = NUM_RF_R_PORTS.
  - If iss_req_v[k] && need[k] <= avail: grant k and assign the next need[k] ports in ascending order, src0 before src1. Decrement avail.
  - Otherwise deny k and continue walking; later slots may still be granted (skip allowed).
  - A requesting slot with need=0 is always granted.
- Ports with no assignment: rf_r_port_en=0, rf_r_port_addr=0.
- rr_ptr update:
  - If any requesting slot is denied, rr_ptr <= first denied slot in walk order.
  - Otherwise rr_ptr is unchanged.
  - This guarantees a denied slot the highest priority next cycle. Since NUM_RF_R_PORTS >= NUM_SRCS, maximum wait is 1 cycle.
- Handshake: a denied slot keeps iss_req_v and its sources stable until granted. The arbiter keeps no request state beyond rr_ptr.
- Steering pipeline, cycle N+1 after a grant in cycle N:
  - rd_sel_v[i][s] = granted[i] && source counted.
  - rd_sel_port holds the port assigned in cycle N.
  - This aligns with regfile rf_r_port_data updating at posedge N+1.
- flush:
  - rd_sel_v <= 0 at the next edge, overriding new grants from the flush cycle.
  - iss_gnt is forced to 0 during flush.
  - rr_ptr holds.
- rst during operation: same edge clears all state; no partial steering survives.
- Write/read ordering against retirement is the regfile's concern, not this block's.

Decomposition:
- Shared package (rtl_constants): ISSUE_WIDTH_MAX, NUM_SRCS, NUM_RF_R_PORTS, SRC_LEN, and a derived RF_R_PORT_IDX_W = $clog2(NUM_RF_R_PORTS).
- Shared package (structs): rd_steer_t {v, port}.
- One sub-module, rf_port_popcount, computes per-slot need and the prefix sums of ports for a rotated slot order. The top keeps rotation, rr_ptr and the steering registers.

Test Plan:
- Reset: assert rst 2 cycles with all requests high -> iss_gnt=0, rd_sel_v=0, rr_ptr=0; first cycle after release all 4 slots request 1 source each -> all granted on ports 0-3.
- Overflow: 4 slots x 2 valid non-zero sources, rr_ptr=0 -> grant slots 0,1,2 on ports 0-5, deny slot 3. Next cycle rr_ptr=3; with the same requests slot 3 is granted on ports 0-1.
- Skip: rr_ptr=0, needs {2,2,1,2} -> slots 0,1 use ports 0-3; slot 2 gets port 4; slot 3 denied; port 5 en=0 with addr=0; rr_ptr becomes 3.
- x0 and zero-need: slot 1 srcs {x0, x7} -> single port, rd_sel_v[1]={0,1}. Slot 2 req with no src_v -> granted, no port used.
- Latency: grant slot 0 src0 on port 2 at cycle N -> cycle N+1 rd_sel_v[0][0]=1, rd_sel_port[0][0]=2; cycle N+2 rd_sel_v=0 if no new grant.
- Flush: grants in cycle N with flush=1 -> iss_gnt=0 in N, rd_sel_v=0 at N+1, rr_ptr unchanged.

Source files
------------

// File: rtl/rf_read_port_arbiter_pkg.sv
// rtl/rf_read_port_arbiter_pkg.sv - shared sizing constants and steering record for the RF read-port arbiter
package rf_read_port_arbiter_pkg;
  localparam int ISSUE_WIDTH_MAX = 4;
  localparam int NUM_SRCS        = 2;
  localparam int NUM_RF_R_PORTS  = 6;
  localparam int SRC_LEN         = 5;
  localparam int RF_R_PORT_IDX_W = $clog2(NUM_RF_R_PORTS);

  typedef struct packed {
    logic                       v;
    logic [RF_R_PORT_IDX_W-1:0] port;
  } rd_steer_t;
endpackage

// File: rtl/rf_port_popcount.sv
// rtl/rf_port_popcount.sv - per-slot port need and round-robin whole-slot allocation with prefix port bases
module rf_port_popcount
  import rf_read_port_arbiter_pkg::*;
#(
  parameter int ISSUE_WIDTH_MAX = rf_read_port_arbiter_pkg::ISSUE_WIDTH_MAX,
  parameter int NUM_SRCS        = rf_read_port_arbiter_pkg::NUM_SRCS,
  parameter int NUM_RF_R_PORTS  = rf_read_port_arbiter_pkg::NUM_RF_R_PORTS,
  parameter int SRC_LEN         = rf_read_port_arbiter_pkg::SRC_LEN,
  parameter int RR_W            = $clog2(ISSUE_WIDTH_MAX),
  parameter int CNT_W           = $clog2(NUM_RF_R_PORTS + 1)
) (
  input  logic [ISSUE_WIDTH_MAX-1:0]                            iss_req_v,
  input  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]              iss_src_v,
  input  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][SRC_LEN-1:0] iss_src_addr,
  input  logic [RR_W-1:0]                                       rr_ptr,
  output logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]              src_cnt,
  output logic [ISSUE_WIDTH_MAX-1:0]                            slot_gnt,
  output logic [ISSUE_WIDTH_MAX-1:0][CNT_W-1:0]                 slot_base,
  output logic                                                  deny_v,
  output logic [RR_W-1:0]                                       deny_idx
);

  logic [ISSUE_WIDTH_MAX-1:0][CNT_W-1:0] need;

  // x0 reads are satisfied by the consumer, so they never take a port
  always_comb begin
    src_cnt = '0;
    need    = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (iss_src_v[i][s] && (iss_src_addr[i][s] != '0)) begin
          src_cnt[i][s] = 1'b1;
          need[i]       = need[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    logic [CNT_W-1:0] avail;
    logic [CNT_W-1:0] used;
    int k;
    avail     = CNT_W'(NUM_RF_R_PORTS);
    used      = '0;
    k         = 0;
    slot_gnt  = '0;
    slot_base = '0;
    deny_v    = 1'b0;
    deny_idx  = '0;
    for (int step = 0; step < ISSUE_WIDTH_MAX; step++) begin
      k = int'(rr_ptr) + step;
      if (k >= ISSUE_WIDTH_MAX) k = k - ISSUE_WIDTH_MAX;
      if (iss_req_v[k]) begin
        if (need[k] <= avail) begin
          slot_gnt[k]  = 1'b1;
          slot_base[k] = used;
          used         = used + need[k];
          avail        = avail - need[k];
        end else if (!deny_v) begin
          deny_v   = 1'b1;
          deny_idx = RR_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// rtl/rf_read_port_arbiter.sv - shares regfile read ports among issue slots and registers the read-data steering
module rf_read_port_arbiter
  import rf_read_port_arbiter_pkg::*;
#(
  parameter int ISSUE_WIDTH_MAX = rf_read_port_arbiter_pkg::ISSUE_WIDTH_MAX,
  parameter int NUM_SRCS        = rf_read_port_arbiter_pkg::NUM_SRCS,
  parameter int NUM_RF_R_PORTS  = rf_read_port_arbiter_pkg::NUM_RF_R_PORTS,
  parameter int SRC_LEN         = rf_read_port_arbiter_pkg::SRC_LEN
) (
  input  logic                                                                     clk,
  input  logic                                                                     rst,
  input  logic                                                                     flush,
  input  logic [ISSUE_WIDTH_MAX-1:0]                                               iss_req_v,
  input  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]                                 iss_src_v,
  input  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][SRC_LEN-1:0]                    iss_src_addr,
  output logic [ISSUE_WIDTH_MAX-1:0]                                               iss_gnt,
  output logic [NUM_RF_R_PORTS-1:0][SRC_LEN-1:0]                                   rf_r_port_addr,
  output logic [NUM_RF_R_PORTS-1:0]                                                rf_r_port_en,
  output logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]                                 rd_sel_v,
  output logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][$clog2(NUM_RF_R_PORTS)-1:0]     rd_sel_port,
  output logic [$clog2(ISSUE_WIDTH_MAX)-1:0]                                       rr_ptr
);

  localparam int RR_W  = $clog2(ISSUE_WIDTH_MAX);
  localparam int IDX_W = $clog2(NUM_RF_R_PORTS);
  localparam int CNT_W = $clog2(NUM_RF_R_PORTS + 1);

  if (NUM_RF_R_PORTS < NUM_SRCS) begin : g_port_check
    $error("rf_read_port_arbiter: NUM_RF_R_PORTS must be >= NUM_SRCS");
  end
  if (IDX_W != RF_R_PORT_IDX_W) begin : g_idx_check
    $error("rf_read_port_arbiter: port index width differs from rd_steer_t");
  end

  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]            src_cnt;
  logic [ISSUE_WIDTH_MAX-1:0]                          slot_gnt;
  logic [ISSUE_WIDTH_MAX-1:0][CNT_W-1:0]               slot_base;
  logic                                                deny_v;
  logic [RR_W-1:0]                                     deny_idx;
  logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][IDX_W-1:0] sel_port;
  rd_steer_t                                           steer_q [ISSUE_WIDTH_MAX][NUM_SRCS];

  rf_port_popcount #(
    .ISSUE_WIDTH_MAX (ISSUE_WIDTH_MAX),
    .NUM_SRCS        (NUM_SRCS),
    .NUM_RF_R_PORTS  (NUM_RF_R_PORTS),
    .SRC_LEN         (SRC_LEN),
    .RR_W            (RR_W),
    .CNT_W           (CNT_W)
  ) u_popcount (
    .iss_req_v    (iss_req_v),
    .iss_src_v    (iss_src_v),
    .iss_src_addr (iss_src_addr),
    .rr_ptr       (rr_ptr),
    .src_cnt      (src_cnt),
    .slot_gnt     (slot_gnt),
    .slot_base    (slot_base),
    .deny_v       (deny_v),
    .deny_idx     (deny_idx)
  );

  assign iss_gnt = (rst || flush) ? '0 : slot_gnt;

  // Each granted slot fills consecutive ports from its base, src0 first
  always_comb begin
    logic [CNT_W-1:0] p;
    p              = '0;
    rf_r_port_addr = '0;
    rf_r_port_en   = '0;
    sel_port       = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      if (iss_gnt[i]) begin
        p = slot_base[i];
        for (int s = 0; s < NUM_SRCS; s++) begin
          if (src_cnt[i][s]) begin
            rf_r_port_addr[p] = iss_src_addr[i][s];
            rf_r_port_en[p]   = 1'b1;
            sel_port[i][s]    = IDX_W'(p);
            p                 = p + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (rst || flush) begin
          steer_q[i][s] <= '0;
        end else begin
          steer_q[i][s].v    <= iss_gnt[i] && src_cnt[i][s];
          steer_q[i][s].port <= sel_port[i][s];
        end
      end
    end
    // The first denied slot leads next cycle, bounding its wait to one cycle
    if (rst) begin
      rr_ptr <= '0;
    end else if (!flush && deny_v) begin
      rr_ptr <= deny_idx;
    end
  end

  always_comb begin
    rd_sel_v    = '0;
    rd_sel_port = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        rd_sel_v[i][s]    = steer_q[i][s].v;
        rd_sel_port[i][s] = steer_q[i][s].port;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// tb/tb_rf_read_port_arbiter.sv - directed self-checking bench for rf_read_port_arbiter
module tb_rf_read_port_arbiter;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [3:0]            iss_req_v;
  logic [3:0][1:0]       iss_src_v;
  logic [3:0][1:0][4:0]  iss_src_addr;
  logic [3:0]            iss_gnt;
  logic [5:0][4:0]       rf_r_port_addr;
  logic [5:0]            rf_r_port_en;
  logic [3:0][1:0]       rd_sel_v;
  logic [3:0][1:0][2:0]  rd_sel_port;
  logic [1:0]            rr_ptr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_read_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .iss_req_v      (iss_req_v),
    .iss_src_v      (iss_src_v),
    .iss_src_addr   (iss_src_addr),
    .iss_gnt        (iss_gnt),
    .rf_r_port_addr (rf_r_port_addr),
    .rf_r_port_en   (rf_r_port_en),
    .rd_sel_v       (rd_sel_v),
    .rd_sel_port    (rd_sel_port),
    .rr_ptr         (rr_ptr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iss_req_v    = '0;
    iss_src_v    = '0;
    iss_src_addr = '0;
  endtask

  task automatic set_slot(input int i, input logic req, input logic v0, input logic [4:0] a0,
                          input logic v1, input logic [4:0] a1);
    iss_req_v[i]       = req;
    iss_src_v[i][0]    = v0;
    iss_src_addr[i][0] = a0;
    iss_src_v[i][1]    = v1;
    iss_src_addr[i][1] = a1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_two_src();
    set_slot(0, 1, 1, 5'd1, 1, 5'd2);
    set_slot(1, 1, 1, 5'd3, 1, 5'd4);
    set_slot(2, 1, 1, 5'd5, 1, 5'd6);
    set_slot(3, 1, 1, 5'd7, 1, 5'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    clear_inputs();
    for (int i = 0; i < 4; i++) set_slot(i, 1, 1, 5'(i + 1), 0, 5'd0);
    #2;
    chk("rst_gnt", iss_gnt, 4'h0);
    tick();
    tick();
    chk("rst_gnt2", iss_gnt, 4'h0);
    chk("rst_sel_v", rd_sel_v, 8'h00);
    chk("rst_sel_port", rd_sel_port, 24'h0);
    chk("rst_rr", rr_ptr, 2'd0);

    // first cycle out of reset: one source per slot
    rst = 1'b0;
    #2;
    chk("one_gnt", iss_gnt, 4'hF);
    chk("one_en", rf_r_port_en, 6'b001111);
    chk("one_addr0", rf_r_port_addr[0], 5'd1);
    chk("one_addr3", rf_r_port_addr[3], 5'd4);
    chk("one_addr4", rf_r_port_addr[4], 5'd0);
    tick();
    chk("one_sel_v", rd_sel_v, 8'h55);
    chk("one_port3", rd_sel_port[3][0], 3'd3);
    chk("one_rr", rr_ptr, 2'd0);

    // overflow: 8 reads for 6 ports
    all_two_src();
    #2;
    chk("ovf_gnt", iss_gnt, 4'b0111);
    chk("ovf_en", rf_r_port_en, 6'b111111);
    chk("ovf_addr5", rf_r_port_addr[5], 5'd6);
    tick();
    chk("ovf_rr", rr_ptr, 2'd3);
    chk("ovf_sel_v", rd_sel_v, 8'h3F);
    chk("ovf_port21", rd_sel_port[2][1], 3'd5);
    chk("ovf_port10", rd_sel_port[1][0], 3'd2);

    // denied slot 3 now leads
    #2;
    chk("rot_gnt", iss_gnt, 4'b1011);
    chk("rot_addr0", rf_r_port_addr[0], 5'd7);
    chk("rot_addr1", rf_r_port_addr[1], 5'd8);
    chk("rot_addr2", rf_r_port_addr[2], 5'd1);
    tick();
    chk("rot_rr", rr_ptr, 2'd2);
    chk("rot_sel_v", rd_sel_v, 8'hCF);
    chk("rot_port31", rd_sel_port[3][1], 3'd1);
    chk("rot_port00", rd_sel_port[0][0], 3'd2);

    // reset mid-operation clears steering and pointer
    rst = 1'b1;
    #2;
    chk("mrst_gnt", iss_gnt, 4'h0);
    tick();
    chk("mrst_sel_v", rd_sel_v, 8'h00);
    chk("mrst_rr", rr_ptr, 2'd0);
    rst = 1'b0;

    // skip: needs {2,2,1,2}
    clear_inputs();
    set_slot(0, 1, 1, 5'd1, 1, 5'd2);
    set_slot(1, 1, 1, 5'd3, 1, 5'd4);
    set_slot(2, 1, 1, 5'd9, 0, 5'd0);
    set_slot(3, 1, 1, 5'd10, 1, 5'd11);
    #2;
    chk("skip_gnt", iss_gnt, 4'b0111);
    chk("skip_en", rf_r_port_en, 6'b011111);
    chk("skip_addr4", rf_r_port_addr[4], 5'd9);
    chk("skip_addr5", rf_r_port_addr[5], 5'd0);
    tick();
    chk("skip_rr", rr_ptr, 2'd3);
    chk("skip_sel_v", rd_sel_v, 8'h1F);
    chk("skip_port20", rd_sel_port[2][0], 3'd4);

    // x0 source and zero-need slot
    clear_inputs();
    set_slot(1, 1, 1, 5'd0, 1, 5'd7);
    set_slot(2, 1, 0, 5'd3, 0, 5'd4);
    #2;
    chk("x0_gnt", iss_gnt, 4'b0110);
    chk("x0_en", rf_r_port_en, 6'b000001);
    chk("x0_addr0", rf_r_port_addr[0], 5'd7);
    tick();
    chk("x0_sel_v", rd_sel_v, 8'h08);
    chk("x0_port11", rd_sel_port[1][1], 3'd0);
    chk("x0_rr", rr_ptr, 2'd3);

    // latency: slot 0 src0 lands on port 2
    clear_inputs();
    set_slot(3, 1, 1, 5'd12, 1, 5'd13);
    set_slot(0, 1, 1, 5'd14, 0, 5'd0);
    #2;
    chk("lat_gnt", iss_gnt, 4'b1001);
    chk("lat_en", rf_r_port_en, 6'b000111);
    chk("lat_addr2", rf_r_port_addr[2], 5'd14);
    tick();
    chk("lat_v00", rd_sel_v[0][0], 1'b1);
    chk("lat_port00", rd_sel_port[0][0], 3'd2);
    chk("lat_sel_v", rd_sel_v, 8'hC1);
    clear_inputs();
    tick();
    chk("lat_idle_v", rd_sel_v, 8'h00);

    // flush suppresses grants, steering and pointer movement
    all_two_src();
    flush = 1'b1;
    #2;
    chk("fl_gnt", iss_gnt, 4'h0);
    chk("fl_en", rf_r_port_en, 6'h00);
    tick();
    chk("fl_sel_v", rd_sel_v, 8'h00);
    chk("fl_rr", rr_ptr, 2'd3);
    flush = 1'b0;
    #2;
    chk("pfl_gnt", iss_gnt, 4'b1011);
    tick();
    chk("pfl_rr", rr_ptr, 2'd2);
    chk("pfl_sel_v", rd_sel_v, 8'hCF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
